// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pin_toggle_seq.sv
// Pin toggle sequencer for characterizing antenna-protected cell inputs.
// Walks the latched enable mask one pin at a time. Each enabled pin gets
// CNT_CFG high/low pulses, and each level is held for DWELL+1 cycles.
// Progress is reported through BUSY, and completion through DONE and ERR.
// Every output is a flop. The comb block computes next values only.
module gf180mcu_fd_sc_mcu9t5v0__pin_toggle_seq #(
    parameter int NPINS   = 4,
    parameter int CNT_W   = 8,
    parameter int DWELL_W = 4
) (
    input  logic                       CLK,
    input  logic                       RN,
    input  logic                       START,
    input  logic                       ABORT,
    input  logic [NPINS-1:0]           PIN_EN,
    input  logic [CNT_W-1:0]           CNT_CFG,
    input  logic [DWELL_W-1:0]         DWELL,
    output logic [NPINS-1:0]           I,
    output logic [$clog2(NPINS)-1:0]   CUR_PIN,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       ERR
);

    localparam int PIN_W = $clog2(NPINS);
    localparam int IDX_W = $clog2(NPINS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [CNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic               level_q, level_d;
    logic [NPINS-1:0]   en_q, en_d;
    logic [CNT_W-1:0]   cnt_cfg_q, cnt_cfg_d;
    logic [DWELL_W-1:0] dwell_cfg_q, dwell_cfg_d;
    logic [NPINS-1:0]   i_d;
    logic [PIN_W-1:0]   cur_pin_d;
    logic               busy_d, done_d, err_d;

    logic [PIN_W-1:0]   pin_sel;
    logic [NPINS-1:0]   pin_onehot;
    logic               last_pulse;

    // Decode the current pin index and detect the final pulse of a pin.
    always_comb begin
        pin_sel    = idx_q[PIN_W-1:0];
        pin_onehot = NPINS'(1) << pin_sel;
        last_pulse = (CNT_W'(pulse_cnt_q + 1'b1) == cnt_cfg_q);
    end

    // Next-state and next-output logic. ABORT takes priority over sequencing.
    always_comb begin
        // NOTE: every variable gets a default first, so no branch can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        dwell_cnt_d = dwell_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        level_d     = level_q;
        en_d        = en_q;
        cnt_cfg_d   = cnt_cfg_q;
        dwell_cfg_d = dwell_cfg_q;
        i_d         = I;
        cur_pin_d   = CUR_PIN;
        busy_d      = BUSY;
        done_d      = 1'b0;
        err_d       = ERR;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    en_d        = PIN_EN;
                    cnt_cfg_d   = CNT_CFG;
                    dwell_cfg_d = DWELL;
                    err_d       = 1'b0;
                    if (PIN_EN == '0 || CNT_CFG == '0) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = SCAN;
                        idx_d   = '0;
                    end
                end
            end

            SCAN: begin
                if (ABORT) begin
                    state_d   = IDLE;
                    i_d       = '0;
                    cur_pin_d = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                end else if (idx_q == IDX_W'(NPINS)) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    cur_pin_d = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b0;
                end else if (en_q[pin_sel]) begin
                    state_d     = DRIVE;
                    i_d         = pin_onehot;
                    cur_pin_d   = pin_sel;
                    dwell_cnt_d = '0;
                    pulse_cnt_d = '0;
                    level_d     = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            DRIVE: begin
                if (ABORT) begin
                    state_d   = IDLE;
                    i_d       = '0;
                    cur_pin_d = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                end else if (dwell_cnt_q == dwell_cfg_q) begin
                    dwell_cnt_d = '0;
                    if (level_q) begin
                        level_d = 1'b0;
                        i_d     = '0;
                    end else if (last_pulse) begin
                        state_d = SCAN;
                        idx_d   = idx_q + 1'b1;
                        i_d     = '0;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + 1'b1;
                        level_d     = 1'b1;
                        i_d         = pin_onehot;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                i_d     = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dwell_cnt_q <= '0;
            pulse_cnt_q <= '0;
            level_q     <= 1'b0;
            // NOTE: the shadow config flops are reset too. They are a few registers, not a RAM, so resetting them is cheap.
            en_q        <= '0;
            cnt_cfg_q   <= '0;
            dwell_cfg_q <= '0;
            I           <= '0;
            CUR_PIN     <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop captures pre-edge values regardless of order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            dwell_cnt_q <= dwell_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            level_q     <= level_d;
            en_q        <= en_d;
            cnt_cfg_q   <= cnt_cfg_d;
            dwell_cfg_q <= dwell_cfg_d;
            I           <= i_d;
            CUR_PIN     <= cur_pin_d;
            BUSY        <= busy_d;
            DONE        <= done_d;
            ERR         <= err_d;
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__pin_toggle_seq.sv
// Scoreboard bench for the pin toggle sequencer. Stimulus pushes the
// expected output snapshot for each upcoming edge. A monitor pops each
// snapshot after its edge and compares it with the outputs.
module tb_gf180mcu_fd_sc_mcu9t5v0__pin_toggle_seq;

    logic       CLK, RN, START, ABORT;
    logic [3:0] PIN_EN;
    logic [7:0] CNT_CFG;
    logic [3:0] DWELL;
    logic [3:0] I;
    logic [1:0] CUR_PIN;
    logic       BUSY, DONE, ERR;

    gf180mcu_fd_sc_mcu9t5v0__pin_toggle_seq #(
        .NPINS(4), .CNT_W(8), .DWELL_W(4)
    ) dut (
        .CLK(CLK), .RN(RN), .START(START), .ABORT(ABORT),
        .PIN_EN(PIN_EN), .CNT_CFG(CNT_CFG), .DWELL(DWELL),
        .I(I), .CUR_PIN(CUR_PIN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    typedef struct packed {
        logic [3:0] i;
        logic [1:0] cur;
        logic       cur_chk;
        logic       busy;
        logic       done;
        logic       err;
    } snap_t;

    typedef struct {
        int    cyc;
        int    tag;
        snap_t s;
    } item_t;

    item_t sb[$];
    int    edge_cnt = 0;
    int    total    = 0;
    int    passed   = 0;
    int    tag      = 0;
    logic  err_m    = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Monitor: after each edge, compare the outputs with every snapshot due at that edge.
    initial begin
        item_t it;
        forever begin
            @(negedge CLK);
            while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                it = sb.pop_front();
                total++;
                if (I == it.s.i && BUSY == it.s.busy && DONE == it.s.done &&
                    ERR == it.s.err && (!it.s.cur_chk || CUR_PIN == it.s.cur))
                    passed++;
                else
                    $display("FAIL wave t%0d e%0d: got I=%b cur=%0d busy=%b done=%b err=%b, want I=%b cur=%0d(chk=%b) busy=%b done=%b err=%b",
                             it.tag, it.cyc, I, CUR_PIN, BUSY, DONE, ERR,
                             it.s.i, it.s.cur, it.s.cur_chk, it.s.busy, it.s.done, it.s.err);
            end
            if (edge_cnt > 0) begin
                total++;
                if ($onehot0(I)) passed++;
                else $display("FAIL onehot e%0d: got I=%b, want one-hot or zero", edge_cnt, I);
            end
        end
    end

    function automatic snap_t mk(logic [3:0] i, logic [1:0] cur, logic cur_chk,
                                 logic busy, logic done, logic err);
        snap_t s;
        s.i = i; s.cur = cur; s.cur_chk = cur_chk;
        s.busy = busy; s.done = done; s.err = err;
        return s;
    endfunction

    // Queue the expectation for the next edge, then step past that edge.
    task automatic tick(input snap_t s);
        item_t it;
        it.cyc = edge_cnt + 1;
        it.tag = tag;
        it.s   = s;
        sb.push_back(it);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n, input logic ab);
        ABORT = ab;
        repeat (n) tick(mk(4'b0, 2'd0, 1'b1, 1'b0, 1'b0, err_m));
        ABORT = 1'b0;
    endtask

    // Build the expected waveform from the timing rules, then drive one run.
    // Each disabled index costs one SCAN edge. An enabled pin costs
    // 2*cnt*(dw+1) DRIVE edges plus one edge back into SCAN. One final edge gives DONE.
    task automatic run(input logic [3:0] en, input logic [7:0] cnt, input logic [3:0] dw,
                       input int abort_at, input int reset_at, input bit poke,
                       input bit start_abort);
        snap_t plan[$];
        snap_t scan_s;
        int    c, d;
        c      = int'(cnt);
        d      = int'(dw) + 1;
        scan_s = mk(4'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tag++;
        if (en == 4'b0 || cnt == 8'd0) begin
            plan.push_back(mk(4'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1));
        end else begin
            plan.push_back(scan_s);
            for (int p = 0; p < 4; p++) begin
                if (!en[p]) begin
                    plan.push_back(scan_s);
                end else begin
                    for (int k = 0; k < 2 * c * d; k++)
                        plan.push_back(mk(((k / d) % 2 == 0) ? (4'b0001 << p) : 4'b0,
                                          2'(p), 1'b1, 1'b1, 1'b0, 1'b0));
                    plan.push_back(scan_s);
                end
            end
            plan.push_back(mk(4'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
        end

        PIN_EN  = en;
        CNT_CFG = cnt;
        DWELL   = dw;
        START   = 1'b1;
        ABORT   = start_abort;
        for (int e = 0; e < plan.size(); e++) begin
            if (e == 1) begin
                START = 1'b0;
                ABORT = 1'b0;
            end
            if (poke && e == 4) begin
                START   = 1'b1;
                PIN_EN  = ~en;
                CNT_CFG = 8'd1;
                DWELL   = 4'd3;
            end
            if (poke && e == 5) START = 1'b0;
            if (e == abort_at) begin
                ABORT = 1'b1;
                tick(mk(4'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1));
                ABORT = 1'b0;
                err_m = 1'b1;
                return;
            end
            if (e == reset_at) begin
                RN = 1'b0;
                tick(mk(4'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
                RN    = 1'b1;
                err_m = 1'b0;
                return;
            end
            tick(plan[e]);
        end
        START = 1'b0;
        ABORT = 1'b0;
        err_m = plan[plan.size() - 1].err;
    endtask

    initial begin
        // Reset held for two edges with START and ABORT asserted.
        RN = 1'b0; START = 1'b1; ABORT = 1'b1;
        PIN_EN = 4'hF; CNT_CFG = 8'd5; DWELL = 4'd0;
        tag = 0;
        tick(mk(4'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tick(mk(4'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        RN = 1'b1; START = 1'b0; ABORT = 1'b0;
        idle(2, 1'b0);

        // Nominal run: pins 0 and 2, two pulses, two-cycle dwell.
        run(4'b0101, 8'd2, 4'd1, -1, -1, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Configuration errors.
        run(4'b0000, 8'd5, 4'd1, -1, -1, 1'b0, 1'b0);
        idle(2, 1'b0);
        run(4'b1111, 8'd0, 4'd1, -1, -1, 1'b0, 1'b0);
        idle(1, 1'b0);

        // Abort at E6, one idle edge, then restart at E8.
        run(4'b0101, 8'd2, 4'd1, 6, -1, 1'b0, 1'b0);
        idle(1, 1'b0);
        run(4'b0101, 8'd2, 4'd1, -1, -1, 1'b0, 1'b0);

        // Inputs disturbed mid-run must not change the waveform. ABORT in IDLE does nothing.
        run(4'b0101, 8'd2, 4'd1, -1, -1, 1'b1, 1'b0);
        idle(3, 1'b1);

        // START and ABORT together in IDLE start a normal run.
        run(4'b0110, 8'd1, 4'd0, -1, -1, 1'b0, 1'b1);
        idle(1, 1'b0);

        // Reset mid-sequence: no DONE, everything clears.
        run(4'b0101, 8'd2, 4'd1, -1, 5, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Boundary: last pin only, maximum count, one-cycle dwell.
        run(4'b1000, 8'hFF, 4'd0, -1, -1, 1'b0, 1'b0);
        idle(2, 1'b0);

        @(negedge CLK);
        #1;
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending snapshots, want 0", sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
